// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and register write-back.
// Runs byte/half/word loads and stores against a word-addressed data memory
// over a req/gnt/rvalid handshake. Non-memory ops pass through in one cycle.
// Illegal or misaligned memory ops return OUT_ERR without touching memory.
// One op is in flight at a time; IN_READY is high only while idle.
// Ports:
//   CLK, RSTN                       clock, async active-low reset
//   IN_VALID/IN_READY               op handshake from execute
//   IN_LOAD, IN_STORE, IN_FUNCT3    memory op kind and size/sign
//   IN_WB, IN_RD                    write-back enable / destination (non-mem ops)
//   IN_RESULT, IN_STORE_DATA        ALU result or byte address, store data
//   MEM_REQ/WE/ADDR/BE/WDATA        memory request (held until MEM_GNT)
//   MEM_GNT, MEM_RVALID, MEM_RDATA  memory grant and read response
//   OUT_VALID/OUT_READY             write-back handshake
//   OUT_WE, OUT_RD, OUT_DATA        write-back payload
//   OUT_ERR                         misaligned or illegal memory op
module mem_stage #(
  parameter int unsigned MEM_ADDR_W = 30
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  IN_LOAD,
  input  logic                  IN_STORE,
  input  logic [2:0]            IN_FUNCT3,
  input  logic                  IN_WB,
  input  logic [4:0]            IN_RD,
  input  logic [31:0]           IN_RESULT,
  input  logic [31:0]           IN_STORE_DATA,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]            MEM_BE,
  output logic [31:0]           MEM_WDATA,
  input  logic                  MEM_GNT,
  input  logic                  MEM_RVALID,
  input  logic [31:0]           MEM_RDATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_WE,
  output logic [4:0]            OUT_RD,
  output logic [31:0]           OUT_DATA,
  output logic                  OUT_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_off_q, ld_off_d;
  logic                  mem_req_d, mem_we_d, out_valid_d, out_we_d, out_err_d;
  logic [MEM_ADDR_W-1:0] mem_addr_d;
  logic [3:0]            mem_be_d;
  logic [31:0]           mem_wdata_d, out_data_d;
  logic [4:0]            out_rd_d;

  logic        is_mem, f3_bad, misal, op_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign IN_READY = (state_q == S_IDLE);

  // Classify the incoming op and build store lanes from the byte offset.
  always_comb begin
    is_mem   = IN_LOAD | IN_STORE;
    f3_bad   = IN_LOAD ? ((IN_FUNCT3 == 3'd3) || (IN_FUNCT3 >= 3'd6))
                       : (IN_FUNCT3 > 3'd2);
    misal    = ((IN_FUNCT3[1:0] == 2'd1) && IN_RESULT[0]) ||
               ((IN_FUNCT3[1:0] == 2'd2) && (IN_RESULT[1:0] != 2'b00));
    op_err   = (IN_LOAD & IN_STORE) | (is_mem & (f3_bad | misal));
    st_be    = 4'b1111;
    st_wdata = IN_STORE_DATA;
    case (IN_FUNCT3[1:0])
      2'd0: begin
        st_be    = 4'b0001 << IN_RESULT[1:0];
        st_wdata = {4{IN_STORE_DATA[7:0]}};
      end
      2'd1: begin
        st_be    = IN_RESULT[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{IN_STORE_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction using the offset and funct3 captured at acceptance.
  always_comb begin
    ld_byte = MEM_RDATA[7:0];
    case (ld_off_q)
      2'd1:    ld_byte = MEM_RDATA[15:8];
      2'd2:    ld_byte = MEM_RDATA[23:16];
      2'd3:    ld_byte = MEM_RDATA[31:24];
      default: ;
    endcase
    ld_half = ld_off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    ld_data = MEM_RDATA;
    case (ld_f3_q[1:0])
      2'd0:    ld_data = {{24{~ld_f3_q[2] & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{~ld_f3_q[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    mem_req_d   = MEM_REQ;
    mem_we_d    = MEM_WE;
    mem_addr_d  = MEM_ADDR;
    mem_be_d    = MEM_BE;
    mem_wdata_d = MEM_WDATA;
    out_valid_d = OUT_VALID;
    out_we_d    = OUT_WE;
    out_rd_d    = OUT_RD;
    out_data_d  = OUT_DATA;
    out_err_d   = OUT_ERR;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          out_rd_d = IN_RD;
          if (op_err) begin
            out_err_d   = 1'b1;
            out_we_d    = 1'b0;
            out_data_d  = '0;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else if (!is_mem) begin
            out_err_d   = 1'b0;
            out_we_d    = IN_WB && (IN_RD != 5'd0);
            out_data_d  = IN_RESULT;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = IN_STORE;
            mem_addr_d  = IN_RESULT[MEM_ADDR_W+1:2];
            mem_be_d    = IN_STORE ? st_be : 4'b1111;
            mem_wdata_d = IN_STORE ? st_wdata : 32'd0;
            ld_f3_d     = IN_FUNCT3;
            ld_off_d    = IN_RESULT[1:0];
            out_err_d   = 1'b0;
            out_we_d    = 1'b0;
            out_data_d  = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (MEM_GNT) begin
          mem_req_d = 1'b0;
          if (MEM_WE) begin
            out_we_d    = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (MEM_RVALID) begin
          out_data_d  = ld_data;
          out_we_d    = (OUT_RD != 5'd0);
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_WDATA <= '0;
      OUT_VALID <= 1'b0;
      OUT_WE    <= 1'b0;
      OUT_RD    <= '0;
      OUT_DATA  <= '0;
      OUT_ERR   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      MEM_REQ   <= mem_req_d;
      MEM_WE    <= mem_we_d;
      MEM_ADDR  <= mem_addr_d;
      MEM_BE    <= mem_be_d;
      MEM_WDATA <= mem_wdata_d;
      OUT_VALID <= out_valid_d;
      OUT_WE    <= out_we_d;
      OUT_RD    <= out_rd_d;
      OUT_DATA  <= out_data_d;
      OUT_ERR   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table, reset corner case and randomized ops for
// mem_stage, with a bench-side memory responder and a byte-level model.
module tb_mem_stage;

  localparam int unsigned AW = 30;

  logic          CLK, RSTN;
  logic          IN_VALID, IN_READY, IN_LOAD, IN_STORE, IN_WB;
  logic [2:0]    IN_FUNCT3;
  logic [4:0]    IN_RD;
  logic [31:0]   IN_RESULT, IN_STORE_DATA;
  logic          MEM_REQ, MEM_WE, MEM_GNT, MEM_RVALID;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_WDATA, MEM_RDATA;
  logic          OUT_VALID, OUT_READY, OUT_WE, OUT_ERR;
  logic [4:0]    OUT_RD;
  logic [31:0]   OUT_DATA;

  int checks = 0;
  int errors = 0;

  mem_stage #(.MEM_ADDR_W(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LOAD(IN_LOAD), .IN_STORE(IN_STORE),
    .IN_FUNCT3(IN_FUNCT3), .IN_WB(IN_WB), .IN_RD(IN_RD), .IN_RESULT(IN_RESULT),
    .IN_STORE_DATA(IN_STORE_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_WE(OUT_WE), .OUT_RD(OUT_RD),
    .OUT_DATA(OUT_DATA), .OUT_ERR(OUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One op plus its memory timing and expected results.
  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] res, sd, rdata;
    int          gd, rvd, rdyd;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_err, e_we;
    logic [31:0] e_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: byte-lane view of the access, no knowledge of the RTL.
  function automatic vec_t model(input vec_t v);
    vec_t  r = v;
    int    off = int'(v.res[1:0]);
    int    n = 1 << v.f3[1:0];
    bit    legal;
    longint val;
    legal     = v.ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 inside {3'd0, 3'd1, 3'd2});
    r.e_err   = (v.ld && v.st) || ((v.ld || v.st) && (!legal || (off % n) != 0));
    r.e_req   = (v.ld || v.st) && !r.e_err;
    r.e_be    = 4'h0;
    r.e_wdata = 32'h0;
    r.e_data  = 32'h0;
    r.e_we    = 1'b0;
    if (!v.ld && !v.st) begin
      r.e_data = v.res;
      r.e_we   = v.wb && (v.rd != 5'd0);
    end else if (r.e_req && v.st) begin
      for (int i = 0; i < 4; i++) begin
        r.e_be[i]          = (i >= off) && (i < off + n);
        r.e_wdata[8*i +: 8] = v.sd[8*(i % n) +: 8];
      end
    end else if (r.e_req) begin
      r.e_be = 4'hF;
      val = longint'(v.rdata >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
      if (v.f3 < 3'd4 && val >= (longint'(1) << (8 * n - 1)))
        val = val - (longint'(1) << (8 * n));
      r.e_data = 32'(val);
      r.e_we   = (v.rd != 5'd0);
    end
    return r;
  endfunction

  // Drive one op, act as memory and write-back consumer, then check everything.
  task automatic run_op(input vec_t v, input bit noise);
    int req_n = 0, out_n = 0, req_first = -1, out_first = -1, gnt_k = 0;
    int req_unst = 0, out_unst = 0, rdy_bad = 0;
    bit granted = 0, rv_sent = 0, done = 0;
    logic [AW-1:0] c_addr;
    logic          c_we;
    logic [3:0]    c_be;
    logic [31:0]   c_wdata;
    logic          o_we, o_err;
    logic [4:0]    o_rd;
    logic [31:0]   o_data;
    check("in_ready_idle", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1; IN_LOAD = v.ld; IN_STORE = v.st; IN_FUNCT3 = v.f3;
    IN_WB = v.wb; IN_RD = v.rd; IN_RESULT = v.res; IN_STORE_DATA = v.sd;
    @(negedge CLK);
    IN_VALID = 1'b0; IN_LOAD = 1'($urandom); IN_STORE = 1'($urandom);
    IN_FUNCT3 = 3'($urandom); IN_RD = 5'($urandom); IN_RESULT = $urandom; IN_STORE_DATA = $urandom;
    for (int k = 0; k < 200 && !done; k++) begin
      MEM_GNT = 1'b0; MEM_RVALID = 1'b0; OUT_READY = 1'b0;
      if (MEM_REQ) begin
        if (req_n == 0) begin
          req_first = k; c_addr = MEM_ADDR; c_we = MEM_WE; c_be = MEM_BE; c_wdata = MEM_WDATA;
        end else if ({MEM_ADDR, MEM_WE, MEM_BE, MEM_WDATA} !== {c_addr, c_we, c_be, c_wdata}) begin
          req_unst++;
        end
        req_n++;
        if (req_n > v.gd) begin
          MEM_GNT = 1'b1; granted = 1; gnt_k = k;
        end else if (noise) begin
          MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
        end
      end
      if (granted && v.ld && !rv_sent && k == gnt_k + v.rvd) begin
        MEM_RVALID = 1'b1; MEM_RDATA = v.rdata; rv_sent = 1;
      end
      if (OUT_VALID) begin
        if (out_n == 0) begin
          out_first = k; o_we = OUT_WE; o_rd = OUT_RD; o_data = OUT_DATA; o_err = OUT_ERR;
        end else if ({OUT_WE, OUT_RD, OUT_DATA, OUT_ERR} !== {o_we, o_rd, o_data, o_err}) begin
          out_unst++;
        end
        if (IN_READY) rdy_bad++;
        if (noise) begin
          MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
        end
        out_n++;
        if (out_n > v.rdyd) begin
          OUT_READY = 1'b1; done = 1;
        end
      end
      @(negedge CLK);
    end
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0; OUT_READY = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL op_timeout: got no write-back handshake, required one within 200 cycles");
      return;
    end
    check("req_cycles", 32'(req_n), v.e_req ? 32'(v.gd + 1) : 32'd0);
    if (v.e_req) begin
      check("req_latency", 32'(req_first), 32'd0);
      check("mem_addr", 32'(c_addr), 32'(v.res >> 2));
      check("mem_we", 32'(c_we), 32'(v.st));
      check("mem_be", 32'(c_be), 32'(v.e_be));
      if (v.st) check("mem_wdata", c_wdata, v.e_wdata);
      check("out_latency_mem", 32'(out_first), v.st ? 32'(gnt_k + 1) : 32'(gnt_k + v.rvd + 1));
    end else begin
      check("out_latency", 32'(out_first), 32'd0);
    end
    check("out_err", 32'(o_err), 32'(v.e_err));
    check("out_we", 32'(o_we), 32'(v.e_we));
    if (!v.e_err && !v.st) begin
      check("out_rd", 32'(o_rd), 32'(v.rd));
      check("out_data", o_data, v.e_data);
    end
    check("req_stable", 32'(req_unst), 32'd0);
    check("out_stable", 32'(out_unst), 32'd0);
    check("in_ready_busy", 32'(rdy_bad), 32'd0);
    check("out_valid_after", 32'(OUT_VALID), 32'd0);
    check("in_ready_after", 32'(IN_READY), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_req"}, 32'(MEM_REQ), 32'd0);
    check({tag, "_mem_we"}, 32'(MEM_WE), 32'd0);
    check({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'd0);
    check({tag, "_mem_be"}, 32'(MEM_BE), 32'd0);
    check({tag, "_mem_wdata"}, MEM_WDATA, 32'd0);
    check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_out_we"}, 32'(OUT_WE), 32'd0);
    check({tag, "_out_rd"}, 32'(OUT_RD), 32'd0);
    check({tag, "_out_data"}, OUT_DATA, 32'd0);
    check({tag, "_out_err"}, 32'(OUT_ERR), 32'd0);
    check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
  endtask

  vec_t tbl[16];

  initial begin
    //        ld    st    f3    wb    rd     res           sd            rdata         gd rvd rdy req   be       wdata         err   we    data
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b1, 5'd5,  32'h12345678, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b0, 1'b1, 32'h12345678};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 5'd0,  32'h12345678, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b0, 1'b0, 32'h12345678};
    tbl[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 5'd4,  32'h00000103, 32'hAABBCCDD, 32'h0,        3, 1, 0, 1'b1, 4'b1000, 32'hDDDDDDDD, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 1'b0, 5'd7,  32'h00000002, 32'h0,        32'h00F00000, 0, 2, 0, 1'b1, 4'hF,    32'h0,        1'b0, 1'b1, 32'hFFFFFFF0};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 1'b0, 5'd7,  32'h00000002, 32'h0,        32'h00F00000, 1, 2, 0, 1'b1, 4'hF,    32'h0,        1'b0, 1'b1, 32'h000000F0};
    tbl[5]  = '{1'b1, 1'b0, 3'd1, 1'b0, 5'd3,  32'h00000006, 32'h0,        32'h80010000, 0, 1, 0, 1'b1, 4'hF,    32'h0,        1'b0, 1'b1, 32'hFFFF8001};
    tbl[6]  = '{1'b1, 1'b0, 3'd2, 1'b0, 5'd3,  32'h00000005, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'd2, 1'b0, 5'd9,  32'h00000010, 32'h0,        32'hDEADBEEF, 0, 3, 5, 1'b1, 4'hF,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 1'b1, 3'd1, 1'b0, 5'd1,  32'h00000022, 32'h1234ABCD, 32'h0,        2, 1, 2, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'd2, 1'b0, 5'd1,  32'h00000040, 32'hCAFEF00D, 32'h0,        0, 1, 0, 1'b1, 4'hF,    32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 3'd2, 1'b0, 5'd2,  32'h00000008, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd5, 1'b0, 5'd1,  32'h00000002, 32'h0,        32'h80010000, 1, 1, 1, 1'b1, 4'hF,    32'h0,        1'b0, 1'b1, 32'h00008001};
    tbl[12] = '{1'b0, 1'b1, 3'd3, 1'b0, 5'd1,  32'h00000000, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b1, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd6, 1'b0, 5'd1,  32'h00000000, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b1, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b0, 5'd0,  32'h00000001, 32'h0,        32'h00008000, 0, 1, 0, 1'b1, 4'hF,    32'h0,        1'b0, 1'b0, 32'hFFFFFF80};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 5'd5,  32'hA5A5A5A5, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0,    32'h0,        1'b0, 1'b0, 32'hA5A5A5A5};

    RSTN = 1'b0; IN_VALID = 1'b0; IN_LOAD = 1'b0; IN_STORE = 1'b0; IN_FUNCT3 = 3'd0;
    IN_WB = 1'b0; IN_RD = 5'd0; IN_RESULT = 32'd0; IN_STORE_DATA = 32'd0;
    MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'd0; OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_state("reset");
    RSTN = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 16; i++) run_op(tbl[i], 1'b0);

    // Reset while waiting on read data, then a late RVALID must be ignored.
    IN_VALID = 1'b1; IN_LOAD = 1'b1; IN_STORE = 1'b0; IN_FUNCT3 = 3'd2; IN_RD = 5'd6;
    IN_RESULT = 32'h00000008;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check("rstwait_req", 32'(MEM_REQ), 32'd1);
    MEM_GNT = 1'b1;
    @(negedge CLK);
    MEM_GNT = 1'b0;
    check("rstwait_busy", 32'(IN_READY), 32'd0);
    RSTN = 1'b0;
    #1;
    check_reset_state("rst_in_wait");
    @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MEM_RVALID = 1'b1; MEM_RDATA = $urandom;
      @(negedge CLK);
      check("late_rvalid_out_valid", 32'(OUT_VALID), 32'd0);
      check("late_rvalid_in_ready", 32'(IN_READY), 32'd1);
    end
    MEM_RVALID = 1'b0;
    @(negedge CLK);

    // Randomized ops against the reference model, with stray RVALID noise.
    for (int i = 0; i < 200; i++) begin
      vec_t v;
      int   kind;
      kind    = int'($urandom_range(0, 9));
      v.ld    = (kind >= 3 && kind <= 5) || kind == 9;
      v.st    = (kind >= 6 && kind <= 8) || kind == 9;
      v.f3    = 3'($urandom_range(0, 7));
      v.wb    = 1'($urandom_range(0, 1));
      v.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.res   = $urandom;
      if ($urandom_range(0, 1) == 1) v.res[1:0] = 2'b00;
      v.sd    = $urandom;
      v.rdata = $urandom;
      v.gd    = int'($urandom_range(0, 3));
      v.rvd   = int'($urandom_range(1, 3));
      v.rdyd  = int'($urandom_range(0, 3));
      v = model(v);
      run_op(v, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
